crossbar_arbiter: RTL and testbench

CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

---
 rtl/crossbar_arbiter.sv | 147 ++++++++++++++
 tb/tb_crossbar_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter.sv
// Round-robin crossbar arbiter: grants one of four CPUs for HOLD_CYCLES cycles,
// then pulses done for one cycle and latches the read data from the owner's lane.

module crossbar_arbiter_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       hit,
  input  logic       clr,
  input  logic [1:0] addr,
  output logic [1:0] sel
);
  // addr is captured only at the grant edge; later changes are ignored
  always_ff @(posedge clk) begin
    if (rst)       sel <= '0;
    else if (load) sel <= hit ? addr : 2'd0;
    else if (clr)  sel <= '0;
  end
endmodule

module crossbar_arbiter #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [1:0]        addr_0,
  input  logic [1:0]        addr_1,
  input  logic [1:0]        addr_2,
  input  logic [1:0]        addr_3,
  input  logic [DATA_W-1:0] xbar_cpu_0,
  input  logic [DATA_W-1:0] xbar_cpu_1,
  input  logic [DATA_W-1:0] xbar_cpu_2,
  input  logic [DATA_W-1:0] xbar_cpu_3,
  output logic [1:0]        scheduler,
  output logic [1:0]        select_0,
  output logic [1:0]        select_1,
  output logic [1:0]        select_2,
  output logic [1:0]        select_3,
  output logic [3:0]        grant,
  output logic [3:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t                             state, state_d;
  logic [1:0]                         ptr, ptr_d, sched_d, pick, rr_idx;
  logic [3:0]                         cnt, cnt_d, grant_d, done_d;
  logic [DATA_W-1:0]                  rdata_d;
  logic                               sel_ld, sel_clr, found;
  logic [NUM_LANES-1:0][1:0]          addr_v, sel_v;
  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_v;

  assign addr_v = {addr_3, addr_2, addr_1, addr_0};
  assign lane_v = {xbar_cpu_3, xbar_cpu_2, xbar_cpu_1, xbar_cpu_0};
  assign select_0 = sel_v[0];
  assign select_1 = sel_v[1];
  assign select_2 = sel_v[2];
  assign select_3 = sel_v[3];

  // first requester at or above ptr, wrapping 3 -> 0
  always_comb begin
    pick   = ptr;
    found  = 1'b0;
    rr_idx = ptr;
    for (int i = 0; i < NUM_LANES; i++) begin
      rr_idx = ptr + 2'(i);
      if (!found && req[rr_idx]) begin
        pick  = rr_idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    sched_d = scheduler;
    grant_d = grant;
    done_d  = '0;
    rdata_d = rdata;
    sel_ld  = 1'b0;
    sel_clr = 1'b0;
    unique case (state)
      IDLE: if (found) begin
        state_d = GRANT;
        sched_d = pick;
        grant_d = 4'd1 << pick;
        cnt_d   = 4'(HOLD_CYCLES - 1);
        sel_ld  = 1'b1;
      end
      GRANT: if (cnt == 4'd0) begin
        state_d = DONE;
        rdata_d = lane_v[scheduler];
        grant_d = '0;
        done_d  = 4'd1 << scheduler;
        ptr_d   = scheduler + 2'd1;
      end else begin
        cnt_d = cnt - 4'd1;
      end
      DONE: begin
        state_d = IDLE;
        sel_clr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      scheduler <= '0;
      grant     <= '0;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      scheduler <= sched_d;
      grant     <= grant_d;
      done      <= done_d;
      rdata     <= rdata_d;
      busy      <= (state_d != IDLE);
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    crossbar_arbiter_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (sel_ld),
      .hit  (pick == 2'(k)),
      .clr  (sel_clr),
      .addr (addr_v[k]),
      .sel  (sel_v[k])
    );
  end
endmodule

// File: tb/tb_crossbar_arbiter.sv
// Bench for crossbar_arbiter: directed vector table, multi-cycle sequences and a
// random run checked against a per-access reference model for HOLD_CYCLES 2, 1, 15.
module tb_crossbar_arbiter;
  localparam int NI = 3;
  localparam int HS [NI] = '{2, 1, 15};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [1:0] ad [4];
  logic [7:0] xb [4];

  logic [1:0] sch [NI];
  logic [1:0] s0 [NI], s1 [NI], s2 [NI], s3 [NI];
  logic [3:0] gnt [NI], dn [NI];
  logic [7:0] rd [NI];
  logic       bsy [NI];

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    crossbar_arbiter #(.DATA_W(8), .HOLD_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15)) dut (
      .clk(clk), .rst(rst), .req(req),
      .addr_0(ad[0]), .addr_1(ad[1]), .addr_2(ad[2]), .addr_3(ad[3]),
      .xbar_cpu_0(xb[0]), .xbar_cpu_1(xb[1]), .xbar_cpu_2(xb[2]), .xbar_cpu_3(xb[3]),
      .scheduler(sch[g]), .select_0(s0[g]), .select_1(s1[g]), .select_2(s2[g]),
      .select_3(s3[g]), .grant(gnt[g]), .done(dn[g]), .rdata(rd[g]), .busy(bsy[g])
    );
  end

  // Reference model: stage 0 idle, 1..H granted cycle number, H+1 done cycle
  int         m_stage [NI], m_owner [NI], m_ptr [NI];
  logic [1:0] m_sch [NI];
  logic [7:0] m_sel [NI];
  logic [7:0] m_rd [NI];
  bit         m_valid = 0;

  task automatic model_step();
    for (int m = 0; m < NI; m++) begin
      if (rst) begin
        m_stage[m] = 0; m_owner[m] = 0; m_ptr[m] = 0;
        m_sch[m] = 0; m_sel[m] = 0; m_rd[m] = 0;
      end else if (m_stage[m] == 0) begin
        if (req != 0) begin
          for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr[m] + i) % 4;
            if (m_stage[m] == 0 && req[k]) begin
              m_owner[m] = k;
              m_stage[m] = 1;
            end
          end
          m_sch[m] = 2'(m_owner[m]);
          m_sel[m] = 8'(ad[m_owner[m]]) << (2 * m_owner[m]);
        end
      end else if (m_stage[m] < HS[m]) begin
        m_stage[m]++;
      end else if (m_stage[m] == HS[m]) begin
        m_rd[m] = xb[m_owner[m]];
        m_ptr[m] = (m_owner[m] + 1) % 4;
        m_stage[m]++;
      end else begin
        m_stage[m] = 0;
        m_sel[m] = 0;
      end
    end
    if (rst) m_valid = 1;
  endtask

  task automatic model_check();
    logic [3:0] eg, ed;
    if (!m_valid) return;
    for (int m = 0; m < NI; m++) begin
      eg = (m_stage[m] >= 1 && m_stage[m] <= HS[m]) ? (4'd1 << m_owner[m]) : 4'd0;
      ed = (m_stage[m] == HS[m] + 1) ? (4'd1 << m_owner[m]) : 4'd0;
      checks++;
      if ({gnt[m], dn[m], sch[m], s3[m], s2[m], s1[m], s0[m], rd[m], bsy[m]} !==
          {eg, ed, m_sch[m], m_sel[m], m_rd[m], m_stage[m] != 0}) begin
        errors++;
        $display("FAIL model h=%0d cyc=%0d got g=%b d=%b s=%0d sel=%h rd=%0d busy=%b exp g=%b d=%b s=%0d sel=%h rd=%0d busy=%b",
          HS[m], cyc, gnt[m], dn[m], sch[m], {s3[m], s2[m], s1[m], s0[m]}, rd[m], bsy[m],
          eg, ed, m_sch[m], m_sel[m], m_rd[m], m_stage[m] != 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    model_check();
  endtask

  task automatic set_addr(input logic [7:0] a);
    for (int k = 0; k < 4; k++) ad[k] = a[2*k +: 2];
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] addr;
    logic [3:0] g, d;
    logic [1:0] s;
    logic [7:0] sel;
    logic       busy;
    logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] q, logic [7:0] a, logic [3:0] g,
                              logic [3:0] d, logic [1:0] s, logic [7:0] sel, logic b, logic [7:0] rdv);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.g = g; v.d = d; v.s = s; v.sel = sel; v.busy = b; v.rd = rdv;
    return v;
  endfunction

  vec_t vecs [24];

  initial begin
    ad = '{default: 2'd0};
    xb = '{8'd120, 8'd160, 8'd50, 8'd255};

    vecs[0]  = mk(1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 4'b0001, 8'h02, 4'b0001, 4'b0000, 0, 8'h02, 1, 0);
    vecs[2]  = mk(0, 4'b0001, 8'h00, 4'b0001, 4'b0000, 0, 8'h02, 1, 0);
    vecs[3]  = mk(0, 4'b0001, 8'h00, 4'b0000, 4'b0001, 0, 8'h02, 1, 120);
    vecs[4]  = mk(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 0, 120);
    vecs[5]  = mk(0, 4'b0010, 8'h04, 4'b0010, 4'b0000, 1, 8'h04, 1, 120);
    vecs[6]  = mk(0, 4'b0000, 8'h0C, 4'b0010, 4'b0000, 1, 8'h04, 1, 120);
    vecs[7]  = mk(0, 4'b0000, 8'h0C, 4'b0000, 4'b0010, 1, 8'h04, 1, 160);
    vecs[8]  = mk(0, 4'b0000, 8'h0C, 4'b0000, 4'b0000, 1, 8'h00, 0, 160);
    vecs[9]  = mk(0, 4'b0100, 8'h10, 4'b0100, 4'b0000, 2, 8'h10, 1, 160);
    vecs[10] = mk(1, 4'b0100, 8'h10, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
    vecs[11] = mk(0, 4'b0101, 8'h31, 4'b0001, 4'b0000, 0, 8'h01, 1, 0);
    vecs[12] = mk(0, 4'b0101, 8'h31, 4'b0001, 4'b0000, 0, 8'h01, 1, 0);
    vecs[13] = mk(0, 4'b0101, 8'h31, 4'b0000, 4'b0001, 0, 8'h01, 1, 120);
    vecs[14] = mk(0, 4'b0101, 8'h31, 4'b0000, 4'b0000, 0, 8'h00, 0, 120);
    vecs[15] = mk(0, 4'b0101, 8'h31, 4'b0100, 4'b0000, 2, 8'h30, 1, 120);
    vecs[16] = mk(0, 4'b0000, 8'h00, 4'b0100, 4'b0000, 2, 8'h30, 1, 120);
    vecs[17] = mk(0, 4'b0000, 8'h00, 4'b0000, 4'b0100, 2, 8'h30, 1, 50);
    vecs[18] = mk(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2, 8'h00, 0, 50);
    vecs[19] = mk(0, 4'b1000, 8'h80, 4'b1000, 4'b0000, 3, 8'h80, 1, 50);
    vecs[20] = mk(0, 4'b1000, 8'h80, 4'b1000, 4'b0000, 3, 8'h80, 1, 50);
    vecs[21] = mk(0, 4'b1001, 8'h81, 4'b0000, 4'b1000, 3, 8'h80, 1, 255);
    vecs[22] = mk(0, 4'b1001, 8'h81, 4'b0000, 4'b0000, 3, 8'h00, 0, 255);
    vecs[23] = mk(0, 4'b1001, 8'h81, 4'b0001, 4'b0000, 0, 8'h01, 1, 255);

    for (int i = 0; i < 24; i++) begin
      rst = vecs[i].rst; req = vecs[i].req; set_addr(vecs[i].addr);
      tick();
      checks++;
      if ({gnt[0], dn[0], sch[0], s3[0], s2[0], s1[0], s0[0], bsy[0], rd[0]} !==
          {vecs[i].g, vecs[i].d, vecs[i].s, vecs[i].sel, vecs[i].busy, vecs[i].rd}) begin
        errors++;
        $display("FAIL vec%0d got g=%b d=%b s=%0d sel=%h busy=%b rd=%0d exp g=%b d=%b s=%0d sel=%h busy=%b rd=%0d",
          i, gnt[0], dn[0], sch[0], {s3[0], s2[0], s1[0], s0[0]}, bsy[0], rd[0],
          vecs[i].g, vecs[i].d, vecs[i].s, vecs[i].sel, vecs[i].busy, vecs[i].rd);
      end
    end

    // All four requesting from reset: grant starts every 4 cycles in order 0,1,2,3,0
    begin
      int starts [$];
      int owners [$];
      logic [3:0] prev;
      rst = 1; req = 0; tick();
      rst = 0; req = 4'b1111; prev = 0;
      for (int c = 0; c < 24; c++) begin
        tick();
        if (gnt[0] != 0 && prev == 0) begin
          starts.push_back(c);
          owners.push_back(int'(sch[0]));
        end
        prev = gnt[0];
      end
      req = 0;
      checks++;
      if (starts.size() < 5) begin
        errors++;
        $display("FAIL rr_all grants seen %0d need 5", starts.size());
      end else begin
        for (int j = 0; j < 5; j++) begin
          checks++;
          if (owners[j] != j % 4 || starts[j] != 4 * j) begin
            errors++;
            $display("FAIL rr_all #%0d got cpu=%0d at=%0d exp cpu=%0d at=%0d",
              j, owners[j], starts[j], j % 4, 4 * j);
          end
        end
      end
    end

    // Grant width per HOLD_CYCLES and done immediately after
    begin
      int width [NI], done_at [NI];
      rst = 1; req = 0; tick();
      rst = 0; req = 4'b0001; ad[0] = 2'd3; tick();
      req = 0;
      for (int m = 0; m < NI; m++) begin width[m] = (gnt[m] == 4'b0001); done_at[m] = -1; end
      for (int c = 1; c < 20; c++) begin
        tick();
        for (int m = 0; m < NI; m++) begin
          if (gnt[m] == 4'b0001) width[m]++;
          if (dn[m] == 4'b0001 && done_at[m] < 0) done_at[m] = c;
        end
      end
      for (int m = 0; m < NI; m++) begin
        checks++;
        if (width[m] != HS[m] || done_at[m] != HS[m]) begin
          errors++;
          $display("FAIL hold h=%0d got width=%0d done_at=%0d exp width=%0d done_at=%0d",
            HS[m], width[m], done_at[m], HS[m], HS[m]);
        end
      end
    end

    // Random traffic against the model
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) != 0) req = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        ad[k] = 2'($urandom_range(0, 3));
        xb[k] = 8'($urandom_range(0, 255));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
